read_scheduler: RTL
===================

Name: read_scheduler

Overview:
- Output-side counterpart of the write-path arbiter: for one output port, picks which of 8 priority queues in SRAM the read engine dequeues next.
- Supports strict priority (SP) or weighted round robin (WRR), selected by sp0_wrr1.
- Schedules at packet granularity: selection changes only after the read engine reports end of packet.
- One instance per output port, between the queue-status logic and the SRAM read engine.

Parameters:
- NUM_QUEUES, 8, number of priority queues; queue index equals priority (7 highest).
- WEIGHT_W, 4, width of each WRR weight and credit counter.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- sp0_wrr1  input  1  0 = SP, 1 = WRR; sampled only in IDLE.
- queue_nempty  input  NUM_QUEUES  bit q set = queue q holds at least one complete packet.
- weights  input  NUM_QUEUES*WEIGHT_W  weight of queue q at [(q+1)*WEIGHT_W-1 : q*WEIGHT_W].
- rd_valid  output  1  a scheduling decision is presented.
- rd_queue  output  3  selected queue index.
- rd_ready  input  1  read engine accepts the decision; handshake = rd_valid & rd_ready.
- pkt_done  input  1  one-cycle pulse when the read engine finishes the granted packet (eop read).

Behaviour:
- Reset (rst=1 at posedge):
  - rd_valid=0, rd_queue=0, state=IDLE, ptr=0.
  - All credits = weights; mode_q = sp0_wrr1.
  - Reset mid-packet abandons the grant; any later pkt_done outside BUSY is ignored.
- FSM has three states: IDLE, ISSUE, BUSY.
- IDLE:
  - If a candidate exists, register rd_queue, set rd_valid=1, go to ISSUE.
  - Latency: queue_nempty seen at edge N gives rd_valid high after edge N+1.
  - If there is no candidate, stay in IDLE.
- ISSUE:
  - rd_valid and rd_queue are held stable until the handshake, independent of queue_nempty changes.
  - On handshake: rd_valid=0, go to BUSY, apply the WRR credit update.
- BUSY:
  - Wait for pkt_done, then go to IDLE.
  - pkt_done in any other state is ignored.
  - Minimum turnaround from pkt_done to the next rd_valid is 2 cycles.
- SP selection: highest-index q with queue_nempty[q]=1.
- WRR eligibility and search:
  - A queue is eligible if queue_nempty[q]=1 and credit[q]!=0.
  - Search is circular starting at ptr inclusive, ascending index, wrapping from 7 to 0.
- WRR round end:
  - If no queue is eligible but some nonempty queue has weight!=0, reload all credits from weights.
  - Select from the reloaded values in the same IDLE cycle.
  - A weight-0 queue is never served in WRR.
  - If all nonempty queues have weight 0, stay in IDLE.
- WRR update on handshake:
  - credit[sel] decrements by 1.
  - If the result is 0, ptr = (sel+1) mod NUM_QUEUES; otherwise ptr = sel (bursting within credit).
- Mode change: when sp0_wrr1 differs from mode_q in IDLE, update mode_q, reload credits, set ptr=0, then select under the new mode in the same cycle.
- In SP mode, credits and ptr are frozen.

Optional Feature:
- Macro: READ_SCHED_STATS_EN.
- When defined:
  - Adds output stat_grant_cnt, width NUM_QUEUES*16, with counter q at [(q+1)*16-1 : q*16].
  - Counter q increments on each handshake with rd_queue=q and saturates at 16'hFFFF.
  - All counters clear on rst.
- When undefined: the port and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package sram_ctl_pkg holds:
  - state encoding constants (IDLE=2'd0, ISSUE=2'd1, BUSY=2'd2);
  - QID_W=3 and STAT_W=16;
  - the default WEIGHT_W.
- Sub-module wrr_pick: combinational circular first-one finder.
  - Inputs: request vector, start pointer.
  - Outputs: found, index.
  - Used for the WRR search; SP uses a plain descending priority encoder.

Test Plan:
- SP basic: sp0_wrr1=0, queue_nempty=8'b0010_0101, rd_ready=1 -> rd_queue=5. After pkt_done with nempty=8'b0000_0101 -> rd_queue=2.
- ISSUE hold: rd_ready=0 for 5 cycles while queue_nempty toggles -> rd_valid and rd_queue stay constant. Handshake on cycle 6 -> BUSY, rd_valid=0.
- WRR weights: weights q0=2, q1=1, q3=3, others 0; all queues nonempty; pkt_done two cycles after each handshake -> grant sequence 0,0,1,3,3,3,0,0,1,...
- WRR round reload:
  - Setup: weights q2=1, q5=1; nempty=8'b0010_0100.
  - Expected grants: 2,5, then reload, then 2,5.
  - All weights 0 with nempty!=0 -> rd_valid never asserts.
- Mode switch and reset:
  - Switch to SP in IDLE -> next grant = highest nonempty queue.
  - Assert rst during BUSY, then pulse pkt_done -> outputs at reset values, no grant issued until nempty re-evaluated from IDLE.
- Stats (with READ_SCHED_STATS_EN): 3 grants to q4 -> stat_grant_cnt[79:64]=3. Preloading near saturation and granting -> counter holds 16'hFFFF.

Source files
------------

// File: rtl/sram_ctl_pkg.sv
// Shared encodings and widths for the SRAM controller scheduling blocks.
package sram_ctl_pkg;

    localparam int QID_W            = 3;
    localparam int STAT_W           = 16;
    localparam int DEF_WEIGHT_W     = 4;
    localparam int DEF_NUM_QUEUES   = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2
    } sched_state_e;

endpackage

// File: rtl/read_scheduler_wrr_pick.sv
// Circular first-one finder: lowest set request at or after start_i, wrapping
// from the top index back to 0.
module wrr_pick #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] start_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    int               pos;
    logic [IDX_W-1:0] pos_l;

    // Walk offsets from farthest to nearest so the nearest request wins last.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        pos     = 0;
        pos_l   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            pos = int'(start_i) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            pos_l = IDX_W'(pos);
            if (req_i[pos_l]) begin
                found_o = 1'b1;
                idx_o   = pos_l;
            end
        end
    end

endmodule

// File: rtl/read_scheduler.sv
// Per-output-port read scheduler: strict priority or weighted round robin over
// the SRAM priority queues, one decision per packet. Optional grant statistics
// are built when READ_SCHED_STATS_EN is defined.
//   state | meaning
//   IDLE  | evaluate candidates, register a decision
//   ISSUE | decision presented, waiting for rd_ready
//   BUSY  | read engine working on the packet, waiting for pkt_done
module read_scheduler
    import sram_ctl_pkg::*;
#(
    parameter int NUM_QUEUES = DEF_NUM_QUEUES,
    parameter int WEIGHT_W   = DEF_WEIGHT_W
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           sp0_wrr1,
    input  logic [NUM_QUEUES-1:0]          queue_nempty,
    input  logic [NUM_QUEUES*WEIGHT_W-1:0] weights,
    output logic                           rd_valid,
    output logic [QID_W-1:0]               rd_queue,
    input  logic                           rd_ready,
    input  logic                           pkt_done
`ifdef READ_SCHED_STATS_EN
    ,
    output logic [NUM_QUEUES*STAT_W-1:0]   stat_grant_cnt
`endif
);

    sched_state_e                           state_q;
    logic                                   rd_valid_q;
    logic [QID_W-1:0]                       rd_queue_q;
    logic [QID_W-1:0]                       ptr_q;
    logic                                   mode_q;
    logic [NUM_QUEUES-1:0][WEIGHT_W-1:0]    credit_q;

    logic [NUM_QUEUES-1:0][WEIGHT_W-1:0]    wt;
    logic [NUM_QUEUES-1:0][WEIGHT_W-1:0]    credit_base;
    logic [QID_W-1:0]                       ptr_base;
    logic                                   mode_chg;
    logic [NUM_QUEUES-1:0]                  elig;
    logic [NUM_QUEUES-1:0]                  reloadable;
    logic                                   need_reload;
    logic [NUM_QUEUES-1:0]                  wrr_req;
    logic                                   wrr_found;
    logic [QID_W-1:0]                       wrr_idx;
    logic                                   sp_found;
    logic [QID_W-1:0]                       sp_idx;
    logic                                   pick_found;
    logic [QID_W-1:0]                       pick_idx;
    logic [QID_W-1:0]                       ptr_after;

    assign wt = weights;

    // A pending mode switch behaves as if credits were already reloaded and
    // the pointer cleared, so the new mode selects in the same IDLE cycle.
    assign mode_chg    = (sp0_wrr1 != mode_q);
    assign credit_base = mode_chg ? wt : credit_q;
    assign ptr_base    = mode_chg ? '0 : ptr_q;

    always_comb begin
        elig       = '0;
        reloadable = '0;
        for (int q = 0; q < NUM_QUEUES; q++) begin
            elig[q]       = queue_nempty[q] && (credit_base[q] != '0);
            reloadable[q] = queue_nempty[q] && (wt[q] != '0);
        end
    end

    assign need_reload = (elig == '0) && (reloadable != '0);
    assign wrr_req     = need_reload ? reloadable : elig;

    wrr_pick #(
        .N     (NUM_QUEUES),
        .IDX_W (QID_W)
    ) u_wrr_pick (
        .req_i   (wrr_req),
        .start_i (ptr_base),
        .found_o (wrr_found),
        .idx_o   (wrr_idx)
    );

    always_comb begin
        sp_found = 1'b0;
        sp_idx   = '0;
        for (int q = 0; q < NUM_QUEUES; q++) begin
            if (queue_nempty[q]) begin
                sp_found = 1'b1;
                sp_idx   = QID_W'(q);
            end
        end
    end

    assign pick_found = sp0_wrr1 ? wrr_found : sp_found;
    assign pick_idx   = sp0_wrr1 ? wrr_idx   : sp_idx;

    assign ptr_after = (int'(rd_queue_q) == NUM_QUEUES - 1) ? '0
                                                             : rd_queue_q + QID_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rd_valid_q <= 1'b0;
            rd_queue_q <= '0;
            ptr_q      <= '0;
            mode_q     <= sp0_wrr1;
            credit_q   <= wt;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (mode_chg) begin
                        mode_q <= sp0_wrr1;
                        ptr_q  <= '0;
                    end
                    if (mode_chg || (sp0_wrr1 && need_reload)) begin
                        credit_q <= wt;
                    end
                    if (pick_found) begin
                        rd_valid_q <= 1'b1;
                        rd_queue_q <= pick_idx;
                        state_q    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (rd_ready) begin
                        rd_valid_q <= 1'b0;
                        state_q    <= ST_BUSY;
                        // Stay on the queue while it has credit left.
                        if (mode_q) begin
                            credit_q[rd_queue_q] <= credit_q[rd_queue_q] - WEIGHT_W'(1);
                            ptr_q <= (credit_q[rd_queue_q] == WEIGHT_W'(1)) ? ptr_after
                                                                            : rd_queue_q;
                        end
                    end
                end
                ST_BUSY: begin
                    if (pkt_done) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    rd_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_queue = rd_queue_q;

`ifdef READ_SCHED_STATS_EN
    logic [NUM_QUEUES-1:0][STAT_W-1:0] stat_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_q <= '0;
        end else if (rd_valid_q && rd_ready) begin
            if (stat_q[rd_queue_q] != '1) begin
                stat_q[rd_queue_q] <= stat_q[rd_queue_q] + STAT_W'(1);
            end
        end
    end

    assign stat_grant_cnt = stat_q;
`endif

endmodule
